modn_timer_scheduler: RTL and testbench
=======================================

Name: modn_timer_scheduler

Overview:
- Round-robin scheduler that shares one runtime-programmable mod-N counter between NREQ requesters.
- Each requester asks for a timed interval of len[i] cycles. The scheduler grants one requester at a time, runs the shared counter from 0 to len-1, and pulses done to that requester.
- Sits between client blocks that need interval timing and the single counter resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, counter and length width in bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester request level; held high until done or abandoned.
- len  input  NREQ*WIDTH  per-requester modulus; requester i occupies bits [i*WIDTH +: WIDTH].
- pause  input  1  freezes the counter while in RUN.
- grant  output  NREQ  one-hot owner of the counter; all zero when idle.
- busy  output  1  high in RUN and DONE.
- cnt  output  WIDTH  shared counter value.
- done  output  NREQ  one-cycle completion pulse to the owner.

Behaviour:
- Reset (async, immediate): state=IDLE, grant=0, busy=0, cnt=0, done=0, rr_ptr=NREQ-1 (so requester 0 has first priority).
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the first set req[k] scanning from rr_ptr+1, wrapping at NREQ.
  - At that edge: grant=onehot(k), rr_ptr=k, latched modulus lm=len[k], cnt=0.
  - Next state is DONE if lm==0, otherwise RUN.
- RUN:
  - If req[k] is low: abort. Next state IDLE, grant=0, cnt=0, no done pulse.
  - Else if pause is high: cnt holds.
  - Else if cnt==lm-1: next state DONE, cnt=0.
  - Else: cnt=cnt+1.
  - Abort has priority over pause; pause has priority over terminal count.
- DONE:
  - done[k]=1 for exactly one cycle; grant stays high.
  - Next edge: state IDLE, grant=0, done=0.
- Latency, no pause:
  - grant rises at edge E.
  - RUN occupies lm cycles with cnt = 0..lm-1.
  - done is high in cycle E+lm, and grant drops at E+lm+1.
  - Arbitration for the next owner happens in IDLE, so grant edges of consecutive owners are lm+2 cycles apart.
- lm is latched at grant; changes to len during RUN are ignored.
- lm==1: RUN lasts one cycle with cnt=0.
- The counter never exceeds lm-1. Arithmetic wraps at 2^WIDTH, which is unreachable because lm-1 <= 2^WIDTH-1.
- Requests arriving during RUN or DONE wait; no new grant is issued before IDLE.
- req dropping during DONE has no effect: the pulse still completes.
- Fairness: with all requesters active, grants rotate 0,1,...,NREQ-1,0,...
- rst asserted mid-RUN clears everything asynchronously. The first grant after reset goes to the lowest-index active requester.

Decomposition:
- Shared package holds state encoding constants (IDLE, RUN, DONE) and a round-robin pick function (onehot plus index from req and pointer).
- One sub-module: modn_count_core.
  - Inputs: clk, rst, clr, en, lm.
  - Outputs: cnt and a terminal flag (cnt==lm-1).
  - This is the loadable-modulus counter the FSM drives.

Test Plan:
- Single requester: req=0001, len0=5 -> grant=0001; cnt 0,1,2,3,4; done[0] pulses in cycle 6 after grant; grant low in cycle 7.
- All four requesting, each len=2 -> grant order 0001, 0010, 0100, 1000, 0001; each grant lasts 3 cycles; exactly one done pulse per grant.
- len0=0 -> grant for one cycle with done[0]=1, cnt stays 0. len0=1 -> one RUN cycle with cnt=0, then done.
- pause high for 3 cycles with len=4 while cnt=2 -> cnt holds at 2 for 3 cycles; done is delayed by exactly 3 cycles.
- req[1] dropped while cnt=3 of len 8 -> next edge: grant=0, cnt=0, no done; a pending req[2] is granted one cycle later.
- rst pulsed mid-RUN (cnt=4) -> grant, busy, cnt, done all 0 immediately. After release with req=1010, grant=0010 first.

Source files
------------

// File: rtl/modn_timer_scheduler_pkg.sv
// Shared types for the mod-N timer scheduler: FSM state encoding and the
// round-robin pick used to choose the next owner of the shared counter.
package modn_timer_scheduler_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_REQ-1:0] onehot;
        logic [IDX_W-1:0]   idx;
    } rr_pick_t;

    // First set request scanning from ptr+1 with wrap at n. Walking the offsets
    // from far to near lets the nearest set request overwrite the others.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input int ptr, input int n);
        rr_pick_t r;
        int       k;
        r = '0;
        for (int off = MAX_REQ; off >= 1; off--) begin
            if (off <= n) begin
                k = (ptr + off) % n;
                if (req[k[IDX_W-1:0]]) begin
                    r.idx                  = k[IDX_W-1:0];
                    r.onehot               = '0;
                    r.onehot[k[IDX_W-1:0]] = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/modn_count_core.sv
// Loadable-modulus counter: counts while enabled, clears on demand, and flags
// the terminal value lm-1 for the scheduler FSM.
module modn_count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] lm,
    output logic [WIDTH-1:0] cnt,
    output logic             term
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign cnt  = r_cnt;
    assign term = (r_cnt == lm - WIDTH'(1));

endmodule

// File: rtl/modn_timer_scheduler.sv
// Round-robin scheduler sharing one mod-N counter between NREQ requesters;
// each grant runs the counter over the owner's latched length, then pulses done.
module modn_timer_scheduler
    import modn_timer_scheduler_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    input  logic                  pause,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      cnt,
    output logic [NREQ-1:0]       done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state, w_nxt_state;
    logic [NREQ-1:0]  r_grant, w_nxt_grant;
    logic [NREQ-1:0]  r_done, w_nxt_done;
    logic             r_busy;
    logic [IW-1:0]    r_rr_ptr;
    logic [WIDTH-1:0] r_lm;
    logic [WIDTH-1:0] w_len_sel;
    logic [MAX_REQ-1:0] w_req_ext;
    rr_pick_t         w_pick;
    logic             w_load, w_clr, w_en, w_term;

    always_comb begin
        w_req_ext           = '0;
        w_req_ext[NREQ-1:0] = req;
    end

    assign w_pick    = rr_pick(w_req_ext, int'(r_rr_ptr), NREQ);
    assign w_len_sel = len[int'(w_pick.idx)*WIDTH +: WIDTH];

    modn_count_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .lm   (r_lm),
        .cnt  (cnt),
        .term (w_term)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_done  = '0;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_load      = 1'b1;
                    w_clr       = 1'b1;
                    w_nxt_grant = w_pick.onehot[NREQ-1:0];
                    // A zero length skips RUN and completes immediately.
                    if (w_len_sel == '0) begin
                        w_nxt_state = ST_DONE;
                        w_nxt_done  = w_pick.onehot[NREQ-1:0];
                    end else begin
                        w_nxt_state = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!(|(req & r_grant))) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_grant = '0;
                    w_clr       = 1'b1;
                end else if (pause) begin
                    w_en = 1'b0;
                end else if (w_term) begin
                    w_nxt_state = ST_DONE;
                    w_nxt_done  = r_grant;
                    w_clr       = 1'b1;
                end else begin
                    w_en = 1'b1;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = '0;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = '0;
                w_clr       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= IW'(NREQ - 1);
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_done  <= w_nxt_done;
            r_busy  <= (w_nxt_state != ST_IDLE);
            if (w_load) begin
                r_rr_ptr <= w_pick.idx[IW-1:0];
            end
        end
    end

    // The modulus is sampled only at grant so len may change freely during RUN.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_lm <= w_len_sel;
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_modn_timer_scheduler.sv
// Randomized bench for modn_timer_scheduler checked against a transaction-level
// reference model of the owner / interval rules.
module tb_modn_timer_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic                  pause;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      cnt;
    logic [NREQ-1:0]       done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the counter, where its interval stands.
    int m_phase, m_owner, m_ptr, m_lm, m_cnt;

    modn_timer_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .pause (pause),
        .grant (grant),
        .busy  (busy),
        .cnt   (cnt),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_grant();
        return (m_phase != P_IDLE) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    function automatic logic [31:0] m_done();
        return (m_phase == P_DONE) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_owner = 0;
        m_ptr   = NREQ - 1;
        m_lm    = 0;
        m_cnt   = 0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        int k;
        bit found;
        case (m_phase)
            P_IDLE: begin
                found = 0;
                for (int off = 1; off <= NREQ; off++) begin
                    k = (m_ptr + off) % NREQ;
                    if (!found && req[k]) begin
                        found   = 1;
                        m_owner = k;
                    end
                end
                if (found) begin
                    m_ptr   = m_owner;
                    m_lm    = int'(len[m_owner*WIDTH +: WIDTH]);
                    m_cnt   = 0;
                    m_phase = (m_lm == 0) ? P_DONE : P_RUN;
                end
            end
            P_RUN: begin
                if (!req[m_owner]) begin
                    m_phase = P_IDLE;
                    m_cnt   = 0;
                end else if (!pause) begin
                    if (m_cnt == m_lm - 1) begin
                        m_phase = P_DONE;
                        m_cnt   = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic compare_all();
        chk("grant", 32'(grant), m_grant());
        chk("done",  32'(done),  m_done());
        chk("busy",  32'(busy),  (m_phase != P_IDLE) ? 32'd1 : 32'd0);
        chk("cnt",   32'(cnt),   32'(m_cnt));
    endtask

    task automatic randomize_inputs();
        logic [31:0] mdone;
        mdone = m_done();
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
                if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
            end else if (mdone[i] && $urandom_range(0, 1) == 0) begin
                req[i] = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                req[i] = 1'b0;
            end
            if ($urandom_range(0, 15) == 0)
                len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 20));
            else
                len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 6));
        end
        pause = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit reached;
        rst   = 1'b1;
        req   = '0;
        len   = '0;
        pause = 1'b0;
        model_reset();
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_cnt",   32'(cnt),   32'd0);
        chk("rst_done",  32'(done),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        randomize_inputs();
        model_step();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            compare_all();
            randomize_inputs();
            model_step();
        end

        // Asynchronous reset in the middle of an interval.
        reached = 0;
        for (int c = 0; c < 200 && !reached; c++) begin
            @(negedge clk);
            compare_all();
            if (m_phase == P_RUN && m_cnt == 4) begin
                reached = 1;
            end else begin
                req   = '1;
                pause = 1'b0;
                for (int i = 0; i < NREQ; i++) len[i*WIDTH +: WIDTH] = WIDTH'(8);
                model_step();
            end
        end
        chk("rst_setup", 32'(reached), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_cnt",   32'(cnt),   32'd0);
        chk("midrst_done",  32'(done),  32'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst   = 1'b0;
        req   = 4'b1010;
        pause = 1'b0;
        model_step();
        @(negedge clk);
        compare_all();
        chk("first_grant_after_rst", 32'(grant), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
